multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32I core. It replaces the single-cycle combinational decode with an FSM that walks each instruction through fetch, decode, execute, memory and writeback. It drives the same control bundle the datapath already consumes (branch, jump, jalr, memtoreg, memwrite, pcsrc, alusrc, regwrite, alucontrol, alu_sub, auipc, lui), plus enable strobes and a memory request/ready handshake. Instructions share one memory port.

Parameters:
MEM_TIMEOUT, 255, max cycles to wait for mem_ready per access; 0 disables the timeout.
INSTRET_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-high reset
instr  input  32  instruction register contents (valid from DECODE onward)
br_taken  input  1  branch condition from ALU, valid in BRANCH state
mem_ready  input  1  memory completes the current access this cycle
mem_req  output  1  memory access request
irwrite  output  1  load instr register (fetch data)
pcwrite  output  1  update PC; one-cycle pulse = instruction retire
branch, jump, jalr, memtoreg, memwrite, pcsrc, alusrc, regwrite, auipc, lui  output  1 each  datapath controls
alucontrol  output  3  ALU op select
alu_sub  output  1  subtract/arith-shift select
illegal  output  1  sticky: undecodable opcode trapped
bus_err  output  1  sticky: memory timeout trapped
state_o  output  4  current state encoding, debug
instret  output  INSTRET_W  retired-instruction count

Behaviour:
- Async reset: state=IDLE, instret=0, illegal=0, bus_err=0, timeout counter=0. All outputs decode from state and are 0 in IDLE.
- IDLE -> FETCH unconditionally on the first clock after reset deasserts.
- FETCH: mem_req=1. On mem_ready: irwrite=1, go to DECODE. Otherwise hold.
- DECODE: op=instr[6:0]. Next state by op:
  - 0000011 or 0100011 -> ADDR
  - 0110011 or 0010011 -> EXEC
  - 1100011 -> BRANCH
  - 1101111 or 1100111 -> JUMP
  - 0110111 or 0010111 -> UPPER
  - 0001111 (FENCE) -> FETCH with pcwrite=1 (NOP)
  - anything else -> TRAP with illegal set
- ADDR: alusrc=1, alucontrol=000, alu_sub=0. Loads go to MEMRD, stores go to MEMWR.
- MEMRD: mem_req=1. On mem_ready go to WBMEM.
- WBMEM: regwrite=1, memtoreg=1, pcwrite=1, then FETCH.
- MEMWR: mem_req=1, memwrite=1. On mem_ready: pcwrite=1, then FETCH. memwrite stays high throughout the wait.
- EXEC: alucontrol=funct3, alusrc=(op==0010011).
  - alu_sub=funct7[5] for R-type; for I-type alu_sub=funct7[5] only when funct3==101, else 0.
  - regwrite=1, pcwrite=1, then FETCH.
- BRANCH: branch=1, alucontrol=funct3, alu_sub=1, pcwrite=1, pcsrc=br_taken, then FETCH.
- JUMP: jump=1, jalr=(op==1100111), regwrite=1, pcwrite=1, pcsrc=1, alusrc=jalr, then FETCH.
- UPPER: lui or auipc per op, alusrc=1, regwrite=1, pcwrite=1, then FETCH.
- TRAP: absorbing state. All controls 0. Only reset exits.
- Minimum latency: ALU/branch/jump/upper 3 cycles, store 4, load 5 (with mem_ready high on the first request cycle).
- instret increments by 1 on every pcwrite cycle and wraps modulo 2^INSTRET_W.
- Timeout counter:
  - Clears on entry to FETCH/MEMRD/MEMWR and whenever mem_ready=1.
  - Increments each mem_req cycle without mem_ready.
  - If MEM_TIMEOUT>0 and the count reaches MEM_TIMEOUT with mem_ready still low: go to TRAP, set bus_err, no irwrite/pcwrite.
  - mem_ready arriving on the same cycle as the timeout takes precedence: access completes, no trap.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.
- Reset asserted mid-access drops mem_req immediately (async) and does not retire.

Test Plan:
- Reset, then instr=0x002081B3 (ADD x3,x1,x2), mem_ready=1 always -> states IDLE, FETCH, DECODE, EXEC; regwrite=pcwrite=1 in EXEC with alucontrol=000, alu_sub=0; instret=1 after 3 cycles.
- 0x40208133 (SUB) then 0x4020D093 (SRAI x1,x1,2) -> alu_sub=1 both; 0x0020C093 (XORI) -> alu_sub=0, alucontrol=100, alusrc=1.
- LW 0x0000A283 with mem_ready delayed 3 cycles in MEMRD -> mem_req held 4 cycles, then WBMEM with regwrite=memtoreg=pcwrite=1; instret +1 only once.
- BEQ 0x00208463 with br_taken=1, then br_taken=0 -> pcsrc=1 then 0; branch=alu_sub=1, regwrite=0 in both.
- instr=0x00000000 -> TRAP, illegal=1 sticky, pcwrite never asserts; reset clears illegal and the FSM fetches again.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> bus_err=1 after 4 request cycles; rerun with mem_ready=1 exactly on the 4th cycle -> no trap, irwrite=1; reset mid-MEMWR -> memwrite drops same cycle, instret unchanged.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer that walks each instruction through fetch, decode,
// execute, memory and writeback, driving the datapath control bundle.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          instr,
    input  logic                 br_taken,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 irwrite,
    output logic                 pcwrite,
    output logic                 branch,
    output logic                 jump,
    output logic                 jalr,
    output logic                 memtoreg,
    output logic                 memwrite,
    output logic                 pcsrc,
    output logic                 alusrc,
    output logic                 regwrite,
    output logic                 auipc,
    output logic                 lui,
    output logic [2:0]           alucontrol,
    output logic                 alu_sub,
    output logic                 illegal,
    output logic                 bus_err,
    output logic [3:0]           state_o,
    output logic [INSTRET_W-1:0] instret
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_ADDR   = 4'd3,
        S_MEMRD  = 4'd4,
        S_WBMEM  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_UPPER  = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             mem_state;
    logic             timeout_hit;
    logic [6:0]       op;
    logic [2:0]       funct3;
    logic             funct7_b5;
    logic             unused_instr;

    assign op           = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7_b5    = instr[30];
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};
    assign state_o      = state;

    // A late mem_ready on the final allowed cycle wins over the timeout.
    assign mem_state   = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign timeout_hit = mem_state && !mem_ready && (MEM_TIMEOUT != 0)
                         && ((32'(wait_cnt) + 32'd1) == MEM_TIMEOUT);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready)        state_next = S_DECODE;
                else if (timeout_hit) state_next = S_TRAP;
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE:  state_next = S_ADDR;
                    OP_RTYPE, OP_ITYPE: state_next = S_EXEC;
                    OP_BRANCH:          state_next = S_BRANCH;
                    OP_JAL, OP_JALR:    state_next = S_JUMP;
                    OP_LUI, OP_AUIPC:   state_next = S_UPPER;
                    OP_FENCE:           state_next = S_FETCH;
                    default:            state_next = S_TRAP;
                endcase
            end
            S_ADDR:   state_next = (op == OP_STORE) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready)        state_next = S_WBMEM;
                else if (timeout_hit) state_next = S_TRAP;
            end
            S_WBMEM:  state_next = S_FETCH;
            S_MEMWR: begin
                if (mem_ready)        state_next = S_FETCH;
                else if (timeout_hit) state_next = S_TRAP;
            end
            S_EXEC, S_BRANCH, S_JUMP, S_UPPER: state_next = S_FETCH;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_IDLE;
        endcase
    end

    // Control outputs decoded from the current state
    always_comb begin
        mem_req    = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        jalr       = 1'b0;
        memtoreg   = 1'b0;
        memwrite   = 1'b0;
        pcsrc      = 1'b0;
        alusrc     = 1'b0;
        regwrite   = 1'b0;
        auipc      = 1'b0;
        lui        = 1'b0;
        alucontrol = 3'b000;
        alu_sub    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                irwrite = mem_ready;
            end
            S_DECODE: pcwrite = (op == OP_FENCE);
            S_ADDR:   alusrc  = 1'b1;
            S_MEMRD:  mem_req = 1'b1;
            S_WBMEM: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                pcwrite  = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                memwrite = 1'b1;
                pcwrite  = mem_ready;
            end
            S_EXEC: begin
                alucontrol = funct3;
                alusrc     = (op == OP_ITYPE);
                // Immediate ops only use funct7 to pick SRAI over SRLI.
                alu_sub    = (op == OP_ITYPE) ? (funct7_b5 && (funct3 == 3'b101)) : funct7_b5;
                regwrite   = 1'b1;
                pcwrite    = 1'b1;
            end
            S_BRANCH: begin
                branch     = 1'b1;
                alucontrol = funct3;
                alu_sub    = 1'b1;
                pcwrite    = 1'b1;
                pcsrc      = br_taken;
            end
            S_JUMP: begin
                jump     = 1'b1;
                jalr     = (op == OP_JALR);
                alusrc   = (op == OP_JALR);
                regwrite = 1'b1;
                pcwrite  = 1'b1;
                pcsrc    = 1'b1;
            end
            S_UPPER: begin
                lui      = (op == OP_LUI);
                auipc    = (op == OP_AUIPC);
                alusrc   = 1'b1;
                regwrite = 1'b1;
                pcwrite  = 1'b1;
            end
            default: ;
        endcase
    end

    // Retire counter, sticky trap flags and memory wait counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret  <= '0;
            illegal  <= 1'b0;
            bus_err  <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (pcwrite) instret <= instret + INSTRET_W'(1);
            if ((state == S_DECODE) && (state_next == S_TRAP)) illegal <= 1'b1;
            if (timeout_hit) bus_err <= 1'b1;
            if (!mem_state || mem_ready) wait_cnt <= '0;
            else if (wait_cnt != '1)     wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: retire-cycle control vectors go through a
// scoreboard queue, state sequencing and trap behaviour are checked inline.
module tb_multicycle_ctrl;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_ADDR   = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_WBMEM  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_UPPER  = 4'd10;
    localparam logic [3:0] S_TRAP   = 4'd11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'd0;
    logic        br_taken = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, irwrite, pcwrite, branch, jump, jalr, memtoreg, memwrite;
    logic        pcsrc, alusrc, regwrite, auipc, lui, alu_sub, illegal, bus_err;
    logic [2:0]  alucontrol;
    logic [3:0]  state_o;
    logic [31:0] instret;

    int          n_cmp = 0;
    int          n_err = 0;
    int          exp_instret = 0;
    int          req_cycles;
    logic [15:0] exp_q[$];
    string       tag_q[$];
    logic [15:0] mon_vec;
    string       mon_tag;

    multicycle_ctrl #(.MEM_TIMEOUT(4), .INSTRET_W(32)) dut (
        .clk(clk), .reset(reset), .instr(instr), .br_taken(br_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .irwrite(irwrite), .pcwrite(pcwrite), .branch(branch), .jump(jump),
        .jalr(jalr), .memtoreg(memtoreg), .memwrite(memwrite), .pcsrc(pcsrc), .alusrc(alusrc),
        .regwrite(regwrite), .auipc(auipc), .lui(lui), .alucontrol(alucontrol), .alu_sub(alu_sub),
        .illegal(illegal), .bus_err(bus_err), .state_o(state_o), .instret(instret)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ctl_vec();
        return {branch, jump, jalr, memtoreg, memwrite, pcsrc, alusrc, regwrite,
                auipc, lui, alucontrol, alu_sub, irwrite, mem_req};
    endfunction

    // b j jr m2r mw ps as rw au lu alu sub irw req
    function automatic logic [15:0] mk(input logic b, input logic j, input logic jr, input logic m2r,
                                       input logic mw, input logic ps, input logic as_, input logic rw,
                                       input logic au, input logic lu, input logic [2:0] alu,
                                       input logic sub, input logic irw, input logic req);
        return {b, j, jr, m2r, mw, ps, as_, rw, au, lu, alu, sub, irw, req};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Every pcwrite must match the oldest expected retirement
    always @(negedge clk) begin
        if (pcwrite === 1'b1) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL retire: observed unexpected pcwrite in state %0d, required none", state_o);
            end
            if (exp_q.size() != 0) begin
                mon_vec = exp_q.pop_front();
                mon_tag = tag_q.pop_front();
                chk({mon_tag, ".ctl"}, 32'(ctl_vec()), 32'(mon_vec));
            end
        end
    end

    // Asserts reset, checks the immediate effect, releases it and lands in FETCH
    task automatic do_reset(input string tag);
        #1;
        reset = 1'b1;
        #1;
        chk({tag, ".rst_state"}, 32'(state_o), 32'(S_IDLE));
        chk({tag, ".rst_memreq"}, 32'(mem_req), 32'd0);
        chk({tag, ".rst_memwrite"}, 32'(memwrite), 32'd0);
        chk({tag, ".rst_instret"}, instret, 32'd0);
        chk({tag, ".rst_illegal"}, 32'(illegal), 32'd0);
        chk({tag, ".rst_buserr"}, 32'(bus_err), 32'd0);
        step();
        reset = 1'b0;
        exp_instret = 0;
        smp();
        chk({tag, ".idle"}, 32'(state_o), 32'(S_IDLE));
        chk({tag, ".idle_ctl"}, 32'(ctl_vec()), 32'd0);
        step();
    endtask

    // Non-memory instruction starting in FETCH with mem_ready high; lat is 2 or 3
    task automatic run_simple(input string tag, input logic [31:0] ins, input int lat,
                              input logic [3:0] exp_st, input logic [15:0] exp_vec);
        instr = ins;
        mem_ready = 1'b1;
        exp_q.push_back(exp_vec);
        tag_q.push_back(tag);
        smp();
        chk({tag, ".instret"}, instret, 32'(exp_instret));
        chk({tag, ".fetch"}, 32'(state_o), 32'(S_FETCH));
        chk({tag, ".irwrite"}, 32'(irwrite), 32'd1);
        step();
        if (lat == 3) begin
            smp();
            chk({tag, ".decode"}, 32'(state_o), 32'(S_DECODE));
            step();
        end
        smp();
        chk({tag, ".exec_state"}, 32'(state_o), 32'(exp_st));
        chk({tag, ".pcwrite"}, 32'(pcwrite), 32'd1);
        step();
        exp_instret++;
    endtask

    // Walk a load/store from FETCH to its memory state
    task automatic to_mem(input string tag, input logic [31:0] ins);
        instr = ins;
        mem_ready = 1'b1;
        smp();
        chk({tag, ".fetch"}, 32'(state_o), 32'(S_FETCH));
        step();
        smp();
        chk({tag, ".decode"}, 32'(state_o), 32'(S_DECODE));
        step();
        smp();
        chk({tag, ".addr"}, 32'(state_o), 32'(S_ADDR));
        chk({tag, ".addr_ctl"}, 32'(ctl_vec()), 32'(mk(0,0,0,0,0,0,1,0,0,0,3'b000,0,0,0)));
        step();
    endtask

    initial begin
        do_reset("init");

        run_simple("add",   32'h002081B3, 3, S_EXEC,   mk(0,0,0,0,0,0,0,1,0,0,3'b000,0,0,0));
        run_simple("sub",   32'h40208133, 3, S_EXEC,   mk(0,0,0,0,0,0,0,1,0,0,3'b000,1,0,0));
        run_simple("srai",  32'h4020D093, 3, S_EXEC,   mk(0,0,0,0,0,0,1,1,0,0,3'b101,1,0,0));
        run_simple("xori",  32'h0020C093, 3, S_EXEC,   mk(0,0,0,0,0,0,1,1,0,0,3'b100,0,0,0));
        br_taken = 1'b1;
        run_simple("beq_t", 32'h00208463, 3, S_BRANCH, mk(1,0,0,0,0,1,0,0,0,0,3'b000,1,0,0));
        br_taken = 1'b0;
        run_simple("beq_n", 32'h00208463, 3, S_BRANCH, mk(1,0,0,0,0,0,0,0,0,0,3'b000,1,0,0));
        run_simple("jal",   32'h008000EF, 3, S_JUMP,   mk(0,1,0,0,0,1,0,1,0,0,3'b000,0,0,0));
        run_simple("jalr",  32'h000080E7, 3, S_JUMP,   mk(0,1,1,0,0,1,1,1,0,0,3'b000,0,0,0));
        run_simple("lui",   32'h123450B7, 3, S_UPPER,  mk(0,0,0,0,0,0,1,1,0,1,3'b000,0,0,0));
        run_simple("auipc", 32'h00001097, 3, S_UPPER,  mk(0,0,0,0,0,0,1,1,1,0,3'b000,0,0,0));
        run_simple("fence", 32'h0000000F, 2, S_DECODE, mk(0,0,0,0,0,0,0,0,0,0,3'b000,0,0,0));

        // Load with mem_ready withheld for three MEMRD cycles
        to_mem("lw", 32'h0000A283);
        mem_ready = 1'b0;
        req_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("lw.memrd_wait", 32'(state_o), 32'(S_MEMRD));
            if (mem_req) req_cycles++;
            step();
        end
        mem_ready = 1'b1;
        exp_q.push_back(mk(0,0,0,1,0,0,0,1,0,0,3'b000,0,0,0));
        tag_q.push_back("lw");
        smp();
        chk("lw.memrd_done", 32'(state_o), 32'(S_MEMRD));
        if (mem_req) req_cycles++;
        step();
        smp();
        chk("lw.wbmem", 32'(state_o), 32'(S_WBMEM));
        chk("lw.req_cycles", 32'(req_cycles), 32'd4);
        step();
        exp_instret++;

        // Store with one wait cycle; memwrite held while waiting
        to_mem("sw", 32'h0020A023);
        mem_ready = 1'b0;
        smp();
        chk("sw.wait_ctl", 32'(ctl_vec()), 32'(mk(0,0,0,0,1,0,0,0,0,0,3'b000,0,0,1)));
        chk("sw.wait_pcwrite", 32'(pcwrite), 32'd0);
        step();
        mem_ready = 1'b1;
        exp_q.push_back(mk(0,0,0,0,1,0,0,0,0,0,3'b000,0,0,1));
        tag_q.push_back("sw");
        smp();
        chk("sw.memwr", 32'(state_o), 32'(S_MEMWR));
        step();
        exp_instret++;

        // mem_ready on the 4th request cycle beats the timeout
        instr = 32'h002081B3;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("race.fetch_wait", 32'(state_o), 32'(S_FETCH));
            step();
        end
        mem_ready = 1'b1;
        smp();
        chk("race.irwrite", 32'(irwrite), 32'd1);
        step();
        exp_q.push_back(mk(0,0,0,0,0,0,0,1,0,0,3'b000,0,0,0));
        tag_q.push_back("race_add");
        smp();
        chk("race.decode", 32'(state_o), 32'(S_DECODE));
        chk("race.buserr", 32'(bus_err), 32'd0);
        step();
        smp();
        chk("race.exec", 32'(state_o), 32'(S_EXEC));
        step();
        exp_instret++;

        // Four request cycles with no mem_ready trap on a bus error
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("tmo.fetch_wait", 32'(state_o), 32'(S_FETCH));
            chk("tmo.irwrite", 32'(irwrite), 32'd0);
            step();
        end
        smp();
        chk("tmo.trap", 32'(state_o), 32'(S_TRAP));
        chk("tmo.buserr", 32'(bus_err), 32'd1);
        chk("tmo.illegal", 32'(illegal), 32'd0);
        chk("tmo.instret", instret, 32'(exp_instret));
        step();
        mem_ready = 1'b1;
        smp();
        chk("tmo.hold", 32'(state_o), 32'(S_TRAP));
        chk("tmo.ctl", 32'(ctl_vec()), 32'd0);
        do_reset("tmo_rst");

        // Undecodable opcode traps and stays trapped
        instr = 32'h00000000;
        mem_ready = 1'b1;
        smp();
        chk("ill.fetch", 32'(state_o), 32'(S_FETCH));
        step();
        smp();
        chk("ill.decode_flag", 32'(illegal), 32'd0);
        step();
        for (int i = 0; i < 3; i++) begin
            mem_ready = i[0];
            smp();
            chk("ill.trap", 32'(state_o), 32'(S_TRAP));
            chk("ill.sticky", 32'(illegal), 32'd1);
            chk("ill.memreq", 32'(mem_req), 32'd0);
            step();
        end
        do_reset("ill_rst");
        run_simple("refetch", 32'h002081B3, 3, S_EXEC, mk(0,0,0,0,0,0,0,1,0,0,3'b000,0,0,0));

        // Reset during a store wait drops memwrite at once and retires nothing
        to_mem("sw_abort", 32'h0020A023);
        mem_ready = 1'b0;
        smp();
        chk("abort.memwrite", 32'(memwrite), 32'd1);
        chk("abort.instret", instret, 32'(exp_instret));
        do_reset("abort_rst");
        smp();
        chk("abort.refetch", 32'(state_o), 32'(S_FETCH));
        chk("sb.drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
